// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants and FSM state type shared by alu_mc and its core
package alu_pkg;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - unsigned shift-add multiply / restoring divide, one bit per cycle
module muldiv_iter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  localparam int CNT_W = $clog2(XLEN);

  logic            busy_q;
  logic            is_div_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] b_q;
  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   rem_diff;

  // Multiply: {hi,lo} holds partial product above the unconsumed multiplier bits.
  // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
  assign add_sum  = {1'b0, hi_q} + {1'b0, b_q};
  assign rem_sh   = {hi_q, lo_q[XLEN-1]};
  assign rem_diff = rem_sh - {1'b0, b_q};

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CNT_W'(XLEN-1));
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (is_div_q) begin
      if (!rem_diff[XLEN]) begin
        hi_d = rem_diff[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_d = rem_sh[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b0};
      end
    end else if (lo_q[0]) begin
      {hi_d, lo_d} = {add_sum, lo_q[XLEN-1:1]};
    end else begin
      {hi_d, lo_d} = {1'b0, hi_q, lo_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
    end else if (start) begin
      busy_q   <= 1'b1;
      is_div_q <= is_div;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= a;
      b_q      <= b;
    end else if (busy_q) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle RV64I + M-extension execution unit with valid/ready and flush
module alu_mc
  import alu_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd,
  output logic            illegal
);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_q, state_d;
  logic [XLEN-1:0] rd_q, rd_d;
  logic            ill_q, ill_d;
  logic            neg_q, neg_d;
  logic            div_op_q, div_op_d;
  logic            hi_sel_q, hi_sel_d;
  logic            rem_sel_q, rem_sel_d;

  logic               accept;
  logic               is_alt, is_m, is_ill, is_rem;
  logic               a_sgn, b_sgn, a_neg, b_neg;
  logic               div_zero, div_ovf;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    base_res, a_mag, b_mag, div_val, fix_res;
  logic [2*XLEN-1:0]  prod;

  logic            core_start, core_busy, core_done;
  logic [XLEN-1:0] core_hi, core_lo;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign rd        = rd_q;
  assign illegal   = ill_q;
  assign accept    = in_valid && in_ready && !flush;
  assign shamt     = rs2[SHAMT_W-1:0];

  always_comb begin
    is_alt = (funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR));
    is_m   = (funct7 == F7_MULDIV);
    is_ill = !((funct7 == F7_BASE) || is_alt || is_m);

    base_res = '0;
    unique case (funct3)
      F3_ADD:  base_res = is_alt ? (rs1 - rs2) : (rs1 + rs2);
      F3_SLL:  base_res = rs1 << shamt;
      F3_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
      F3_SLTU: base_res = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
      F3_XOR:  base_res = rs1 ^ rs2;
      F3_SR: begin
        if (is_alt) base_res = $signed(rs1) >>> shamt;
        else        base_res = rs1 >> shamt;
      end
      F3_OR:   base_res = rs1 | rs2;
      F3_AND:  base_res = rs1 & rs2;
    endcase

    // MUL needs no sign handling: the low half of the product is sign-agnostic.
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (funct3)
      F3_MULH, F3_DIV, F3_REM: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      F3_MULHSU: a_sgn = 1'b1;
      default: ;
    endcase

    a_neg    = a_sgn && rs1[XLEN-1];
    b_neg    = b_sgn && rs2[XLEN-1];
    a_mag    = a_neg ? -rs1 : rs1;
    b_mag    = b_neg ? -rs2 : rs2;
    is_rem   = (funct3 == F3_REM) || (funct3 == F3_REMU);
    div_zero = (rs2 == '0);
    div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) && (rs1 == SMIN) && (rs2 == '1);
  end

  always_comb begin
    prod = {core_hi, core_lo};
    if (neg_q) prod = -prod;
    div_val = rem_sel_q ? core_hi : core_lo;
    if (neg_q) div_val = -div_val;
    if (div_op_q)      fix_res = div_val;
    else if (hi_sel_q) fix_res = prod[2*XLEN-1:XLEN];
    else               fix_res = prod[XLEN-1:0];
  end

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    ill_d      = ill_q;
    neg_d      = neg_q;
    div_op_d   = div_op_q;
    hi_sel_d   = hi_sel_q;
    rem_sel_d  = rem_sel_q;
    core_start = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          ill_d   = 1'b0;
          state_d = DONE;
          if (is_ill) begin
            rd_d  = '0;
            ill_d = 1'b1;
          end else if (!is_m) begin
            rd_d = base_res;
          end else if (!funct3[2]) begin
            core_start = 1'b1;
            neg_d      = a_neg ^ b_neg;
            div_op_d   = 1'b0;
            hi_sel_d   = (funct3 != F3_MUL);
            state_d    = MUL;
          end else if (div_zero) begin
            rd_d = is_rem ? rs1 : '1;
          end else if (div_ovf) begin
            rd_d = is_rem ? '0 : rs1;
          end else begin
            core_start = 1'b1;
            neg_d      = is_rem ? a_neg : (a_neg ^ b_neg);
            div_op_d   = 1'b1;
            rem_sel_d  = is_rem;
            state_d    = DIV;
          end
        end
      end
      MUL, DIV: begin
        if (core_busy && core_done) state_d = FIX;
      end
      FIX: begin
        rd_d    = fix_res;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_q      <= '0;
      ill_q     <= 1'b0;
      neg_q     <= 1'b0;
      div_op_q  <= 1'b0;
      hi_sel_q  <= 1'b0;
      rem_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      ill_q     <= ill_d;
      neg_q     <= neg_d;
      div_op_q  <= div_op_d;
      hi_sel_q  <= hi_sel_d;
      rem_sel_q <= rem_sel_d;
    end
  end

  muldiv_iter #(.XLEN(XLEN)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (core_start),
    .is_div (funct3[2]),
    .a      (a_mag),
    .b      (b_mag),
    .busy   (core_busy),
    .done   (core_done),
    .hi     (core_hi),
    .lo     (core_lo)
  );

endmodule
